// File: rtl/axi4_burst_mul_slave_pkg.sv
// Shared types and helpers for the burst multiplier slave: response grading,
// FSM states and the beat-map geometry derived from SZ/DSZ.
package axi4_mul_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    function automatic int ob_cnt(input int sz, input int dsz);
        return sz / dsz;
    endfunction

    function automatic int p_lo(input int sz, input int dsz);
        return 2 * ob_cnt(sz, dsz);
    endfunction

    function automatic int p_end(input int sz, input int dsz);
        return 4 * ob_cnt(sz, dsz);
    endfunction

    // Encodings are ordered by severity, so the numerically larger one wins.
    function automatic resp_t worst(input resp_t a, input resp_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        case (burst)
            BURST_INCR: return 1'b0;
            BURST_WRAP: return !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/axi4_burst_mul_slave_if.sv
// AXI4 bus bundle for the burst multiplier slave. AXI4_WRAP_BURST_EN adds
// the awburst/arburst signals.
interface axi4_burst_mul_slave_if #(
    parameter int ASZ = 4,
    parameter int DSZ = 8
);
    logic [ASZ-1:0] awaddr;
    logic [7:0]     awlen;
    logic           awvalid, awready;
    logic [DSZ-1:0] wdata;
    logic           wlast, wvalid, wready;
    logic [1:0]     bresp;
    logic           bvalid, bready;
    logic [ASZ-1:0] araddr;
    logic [7:0]     arlen;
    logic           arvalid, arready;
    logic [DSZ-1:0] rdata;
    logic [1:0]     rresp;
    logic           rlast, rvalid, rready;
`ifdef AXI4_WRAP_BURST_EN
    logic [1:0]     awburst, arburst;
`endif

    modport slave (
`ifdef AXI4_WRAP_BURST_EN
        input  awburst, arburst,
`endif
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        input  araddr, arlen, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport master (
`ifdef AXI4_WRAP_BURST_EN
        output awburst, arburst,
`endif
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        output araddr, arlen, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_burst_mul_slave_regs.sv
// Operand/product storage and beat-address decode. P tracks the post-write
// operands, so it is consistent one cycle after any operand beat.
module axi4_mul_regs
    import axi4_mul_pkg::*;
#(
    parameter int SZ  = 32,
    parameter int DSZ = 8,
    parameter int AW  = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en_i,
    input  logic [AW-1:0]  wr_addr_i,
    input  logic [DSZ-1:0] wr_data_i,
    output resp_t          wr_resp_o,
    input  logic [AW-1:0]  rd_addr_i,
    output logic [DSZ-1:0] rd_data_o,
    output resp_t          rd_resp_o
);
    localparam int OB = ob_cnt(SZ, DSZ);
    localparam int IW = $clog2(2 * OB);
    localparam logic [AW-1:0] P_LO  = AW'(p_lo(SZ, DSZ));
    localparam logic [AW-1:0] P_END = AW'(p_end(SZ, DSZ));

    logic [2*OB-1:0][DSZ-1:0] ab_q, ab_d, p_q;
    logic [2*SZ-1:0]          p_d;
    logic [IW-1:0]            pidx;

    always_comb begin
        if (wr_addr_i < P_LO)       wr_resp_o = OKAY;
        else if (wr_addr_i < P_END) wr_resp_o = SLVERR;
        else                        wr_resp_o = DECERR;
    end

    always_comb begin
        ab_d = ab_q;
        if (wr_en_i && wr_resp_o == OKAY) ab_d[wr_addr_i[IW-1:0]] = wr_data_i;
    end

    assign p_d = {{SZ{1'b0}}, ab_d[OB-1:0]} * {{SZ{1'b0}}, ab_d[2*OB-1:OB]};

    // Modular subtraction on the low bits is exact inside the P window.
    assign pidx = rd_addr_i[IW-1:0] - P_LO[IW-1:0];

    always_comb begin
        rd_data_o = '0;
        rd_resp_o = DECERR;
        if (rd_addr_i < P_LO) begin
            rd_data_o = ab_q[rd_addr_i[IW-1:0]];
            rd_resp_o = OKAY;
        end else if (rd_addr_i < P_END) begin
            rd_data_o = p_q[pidx];
            rd_resp_o = OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ab_q <= '0;
            p_q  <= '0;
        end else begin
            ab_q <= ab_d;
            p_q  <= p_d;
        end
    end
endmodule

// File: rtl/axi4_burst_mul_slave.sv
// AXI4 burst slave around a multiplier: independent write and read FSMs over
// a beat-addressed A/B/P window. AXI4_WRAP_BURST_EN enables WRAP bursts.
module axi4_burst_mul_slave
    import axi4_mul_pkg::*;
#(
    parameter int SZ  = 32,
    parameter int DSZ = 8,
    parameter int ASZ = 4
) (
    input logic                     clk,
    input logic                     rst,
    axi4_burst_mul_slave_if.slave   bus
);
    localparam int AW = 8 + ASZ;

    wstate_t        w_state_q, w_state_d;
    rstate_t        r_state_q, r_state_d;
    logic [AW-1:0]  waddr_q, waddr_d, raddr_q, raddr_d, rd_addr;
    logic [7:0]     wcnt_q, wcnt_d, wlen_q, wlen_d, rcnt_q, rcnt_d, rlen_q, rlen_d;
    logic           wwrap_q, wwrap_d, wbad_q, wbad_d, rwrap_q, rwrap_d, rbad_q, rbad_d;
    resp_t          werr_q, werr_d, rresp_q, rresp_d, wr_resp, rd_resp, wbeat;
    logic [DSZ-1:0] rdata_q, rdata_d, rd_data;
    logic           rlast_q, rlast_d, wr_en, rd_bad, rload;

    // Counters are wider than the bus address so INCR runs off the map into DECERR.
    function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input logic wrap,
                                          input logic [7:0] len);
        logic [AW-1:0] m;
        m = AW'(len);
        return wrap ? ((a & ~m) | ((a + AW'(1)) & m)) : (a + AW'(1));
    endfunction

    axi4_mul_regs #(.SZ(SZ), .DSZ(DSZ), .AW(AW)) u_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (waddr_q),
        .wr_data_i (bus.wdata),
        .wr_resp_o (wr_resp),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .rd_resp_o (rd_resp)
    );

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wcnt_d    = wcnt_q;
        wlen_d    = wlen_q;
        wwrap_d   = wwrap_q;
        wbad_d    = wbad_q;
        werr_d    = werr_q;
        wbeat     = wbad_q ? SLVERR : wr_resp;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: if (bus.awvalid) begin
                waddr_d   = AW'(bus.awaddr);
                wcnt_d    = bus.awlen;
                wlen_d    = bus.awlen;
                werr_d    = OKAY;
`ifdef AXI4_WRAP_BURST_EN
                wwrap_d   = (bus.awburst == BURST_WRAP);
                wbad_d    = burst_bad(bus.awburst, bus.awlen);
`else
                wwrap_d   = 1'b0;
                wbad_d    = 1'b0;
`endif
                w_state_d = W_DATA;
            end
            W_DATA: if (bus.wvalid) begin
                wr_en  = (wbeat == OKAY);
                werr_d = worst(werr_q, wbeat);
                if (bus.wlast != (wcnt_q == 8'd0)) werr_d = worst(werr_d, SLVERR);
                if (wcnt_q == 8'd0) begin
                    w_state_d = W_RESP;
                end else begin
                    wcnt_d  = wcnt_q - 8'd1;
                    waddr_d = adv(waddr_q, wwrap_q, wlen_q);
                end
            end
            W_RESP: if (bus.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Address of the beat to be presented next: the AR address when idle.
    always_comb begin
        if (r_state_q == R_IDLE) begin
            rd_addr = AW'(bus.araddr);
`ifdef AXI4_WRAP_BURST_EN
            rd_bad  = burst_bad(bus.arburst, bus.arlen);
`else
            rd_bad  = 1'b0;
`endif
        end else begin
            rd_addr = adv(raddr_q, rwrap_q, rlen_q);
            rd_bad  = rbad_q;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        rlen_d    = rlen_q;
        rwrap_d   = rwrap_q;
        rbad_d    = rbad_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rload     = 1'b0;
        case (r_state_q)
            R_IDLE: if (bus.arvalid) begin
                r_state_d = R_DATA;
                rcnt_d    = bus.arlen;
                rlen_d    = bus.arlen;
                rbad_d    = rd_bad;
`ifdef AXI4_WRAP_BURST_EN
                rwrap_d   = (bus.arburst == BURST_WRAP);
`else
                rwrap_d   = 1'b0;
`endif
                rload     = 1'b1;
            end
            R_DATA: if (bus.rready) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                    rdata_d   = '0;
                    rresp_d   = OKAY;
                    rlast_d   = 1'b0;
                end else begin
                    rcnt_d = rcnt_q - 8'd1;
                    rload  = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rload) begin
            raddr_d = rd_addr;
            rdata_d = rd_bad ? '0 : rd_data;
            rresp_d = rd_bad ? SLVERR : rd_resp;
            rlast_d = (rcnt_d == 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wcnt_q    <= '0;
            wlen_q    <= '0;
            wwrap_q   <= 1'b0;
            wbad_q    <= 1'b0;
            werr_q    <= OKAY;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rlen_q    <= '0;
            rwrap_q   <= 1'b0;
            rbad_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wcnt_q    <= wcnt_d;
            wlen_q    <= wlen_d;
            wwrap_q   <= wwrap_d;
            wbad_q    <= wbad_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rlen_q    <= rlen_d;
            rwrap_q   <= rwrap_d;
            rbad_q    <= rbad_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign bus.awready = (w_state_q == W_IDLE);
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bresp   = (w_state_q == W_RESP) ? werr_q : OKAY;
    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_DATA);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
endmodule

// File: tb/tb_axi4_burst_mul_slave.sv
// Directed + randomized bench for axi4_burst_mul_slave against a byte-array
// model of the A/B/P window.
module tb_axi4_burst_mul_slave;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_burst_mul_slave_if #(.ASZ(4), .DSZ(8)) bus ();
    axi4_burst_mul_slave #(.SZ(32), .DSZ(8), .ASZ(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int LIM = 64;
    int checks = 0;
    int errs   = 0;
    logic [7:0] ab [8];
    logic [7:0] wq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prod();
        logic [63:0] a, b;
        a = {32'd0, ab[3], ab[2], ab[1], ab[0]};
        b = {32'd0, ab[7], ab[6], ab[5], ab[4]};
        return a * b;
    endfunction

    function automatic bit bad_burst(input logic [1:0] b, input int len);
        if (b == 2'b01) return 1'b0;
        if (b == 2'b10) return !((len + 1) inside {2, 4, 8, 16});
        return 1'b1;
    endfunction

    function automatic int baddr(input int start, input int len, input int i, input bit wrap);
        int l;
        l = len + 1;
        if (!wrap) return start + i;
        return (start - start % l) + ((start % l) + i) % l;
    endfunction

    function automatic logic [7:0] exp_data(input int a);
        logic [63:0] p;
        p = prod();
        if (a < 8)  return ab[a];
        if (a < 16) return p[(a-8)*8 +: 8];
        return 8'h00;
    endfunction

    task automatic wr_burst(input int addr, input int len, input logic [1:0] burst,
                            input bit badlast, input int bstall);
        logic [7:0] d;
        logic [1:0] r, ex;
        int n, a;
        bit bad, wrap;
        bad  = bad_burst(burst, len);
        wrap = (burst == 2'b10);
        ex   = 2'd0;
        bus.awaddr  = 4'(addr);
        bus.awlen   = 8'(len);
`ifdef AXI4_WRAP_BURST_EN
        bus.awburst = burst;
`endif
        bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        chk("aw_wait", 64'(n < LIM), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            d = (wq.size() > 0) ? wq.pop_front() : 8'($urandom);
            bus.wdata  = d;
            bus.wlast  = ((i == len) != badlast);
            bus.wvalid = 1'b1;
            n = 0;
            while (bus.wready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
            chk("w_wait", 64'(n < LIM), 64'd1);
            @(negedge clk);
            a = baddr(addr, len, i, wrap);
            if (bad)         r = 2'd2;
            else if (a < 8)  r = 2'd0;
            else if (a < 16) r = 2'd2;
            else             r = 2'd3;
            if (r == 2'd0) ab[a] = d;
            if (r > ex) ex = r;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        if (badlast && ex < 2'd2) ex = 2'd2;
        bus.bready = (bstall == 0);
        n = 0;
        while (bus.bvalid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        chk("b_wait", 64'(n < LIM), 64'd1);
        chk($sformatf("bresp@%0d+%0d", addr, len), bus.bresp, ex);
        for (int s = 0; s < bstall; s++) begin
            @(negedge clk);
            chk("b_hold_valid", bus.bvalid, 1);
            chk("b_hold_resp", bus.bresp, ex);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk("b_done", bus.bvalid, 0);
        chk("aw_ready_after", bus.awready, 1);
    endtask

    task automatic rd_burst(input int addr, input int len, input logic [1:0] burst, input bit stall);
        logic [7:0] ed;
        logic [1:0] er;
        int n, a;
        bit bad, wrap;
        bad  = bad_burst(burst, len);
        wrap = (burst == 2'b10);
        bus.araddr  = 4'(addr);
        bus.arlen   = 8'(len);
`ifdef AXI4_WRAP_BURST_EN
        bus.arburst = burst;
`endif
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        chk("ar_wait", 64'(n < LIM), 64'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (bus.rvalid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
            chk("r_wait", 64'(n < LIM), 64'd1);
            a  = baddr(addr, len, i, wrap);
            er = bad ? 2'd2 : ((a < 16) ? 2'd0 : 2'd3);
            ed = (er == 2'd0) ? exp_data(a) : 8'h00;
            chk($sformatf("rdata@%0d", a), bus.rdata, ed);
            chk($sformatf("rresp@%0d", a), bus.rresp, er);
            chk($sformatf("rlast@%0d", i), bus.rlast, (i == len));
            if (stall) begin
                bus.rready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("r_stall_valid", bus.rvalid, 1);
                    chk("r_stall_data", bus.rdata, ed);
                    chk("r_stall_last", bus.rlast, (i == len));
                end
            end
            bus.rready = 1'b1;
            @(negedge clk);
            bus.rready = 1'b0;
        end
        chk("r_done", bus.rvalid, 0);
        chk("ar_ready_after", bus.arready, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_awready"}, bus.awready, 1);
        chk({tag, "_arready"}, bus.arready, 1);
        chk({tag, "_wready"},  bus.wready, 0);
        chk({tag, "_bvalid"},  bus.bvalid, 0);
        chk({tag, "_rvalid"},  bus.rvalid, 0);
        chk({tag, "_rlast"},   bus.rlast, 0);
        chk({tag, "_bresp"},   bus.bresp, 0);
        chk({tag, "_rresp"},   bus.rresp, 0);
        chk({tag, "_rdata"},   bus.rdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
`ifdef AXI4_WRAP_BURST_EN
        bus.awburst = 2'b01; bus.arburst = 2'b01;
`endif
        foreach (ab[i]) ab[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");

        // A = 12551, B = 41245, read back the full product window
        wq = '{8'h07, 8'h31, 8'h00, 8'h00};
        wr_burst(0, 3, 2'b01, 1'b0, 0);
        wq = '{8'h1D, 8'hA1, 8'h00, 8'h00};
        wr_burst(4, 3, 2'b01, 1'b0, 0);
        rd_burst(8, 7, 2'b01, 1'b0);

        // A = 2, B = 3 in one burst
        wq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        wr_burst(0, 7, 2'b01, 1'b0, 0);
        rd_burst(8, 0, 2'b01, 1'b0);

        // Error grading: P-region + off-map, then P-only, then bad wlast
        wr_burst(14, 3, 2'b01, 1'b0, 0);
        wr_burst(8, 0, 2'b01, 1'b0, 0);
        rd_burst(8, 7, 2'b01, 1'b0);
        wr_burst(0, 3, 2'b01, 1'b1, 0);
        rd_burst(14, 4, 2'b01, 1'b0);

        // Backpressure on both response channels
        rd_burst(0, 7, 2'b01, 1'b1);
        wr_burst(4, 1, 2'b01, 1'b0, 5);

        for (int k = 0; k < 12; k++) begin
            wr_burst($urandom_range(0, 15), $urandom_range(0, 5), 2'b01, 1'b0, $urandom_range(0, 2));
            rd_burst($urandom_range(0, 15), $urandom_range(0, 7), 2'b01, 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 4; k++) begin
            wr_burst(0, 7, 2'b01, 1'b0, 0);
            rd_burst(8, 7, 2'b01, 1'b0);
        end

        // Reset in the middle of a 4-beat write and a 4-beat read
        bus.awaddr = 4'd0; bus.awlen = 8'd3; bus.awvalid = 1'b1;
        bus.araddr = 4'd8; bus.arlen = 8'd3; bus.arvalid = 1'b1;
`ifdef AXI4_WRAP_BURST_EN
        bus.awburst = 2'b01; bus.arburst = 2'b01;
`endif
        @(negedge clk);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        bus.wdata = 8'h5A; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        chk("pre_rst_rvalid", bus.rvalid, 1);
        chk("pre_rst_wready", bus.wready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        foreach (ab[i]) ab[i] = 8'h00;
        chk_idle("midrst");
        @(negedge clk);
        chk("midrst_no_b", bus.bvalid, 0);
        rd_burst(0, 15, 2'b01, 1'b0);

`ifdef AXI4_WRAP_BURST_EN
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_burst(2, 3, 2'b10, 1'b0, 0);
        rd_burst(0, 3, 2'b01, 1'b0);
        wr_burst(0, 2, 2'b10, 1'b0, 0);
        wr_burst(0, 1, 2'b00, 1'b0, 0);
        wr_burst(4, 7, 2'b10, 1'b0, 0);
        rd_burst(5, 3, 2'b10, 1'b0);
        rd_burst(0, 2, 2'b10, 1'b0);
        rd_burst(0, 1, 2'b11, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
